// File: rtl/parity_check_decoder_3stage.sv
// Receive-side parity checker and function-code decoder.
// Three register ranks: capture, check/decode, output. Fixed two-edge latency
// from capture to outputs, one beat per cycle, no stall. A saturating error
// counter and a sticky error flag track failing beats as they reach rank 3.
module parity_check_decoder_3stage #(
  parameter int ERR_COUNT_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       inValid,
  input  logic [2:0]                 encodedCode,
  input  logic [3:0]                 resultData,
  input  logic                       parityBit,
  input  logic                       clearErrors,
  output logic                       outValid,
  output logic [7:0]                 functionCode,
  output logic [3:0]                 resultOut,
  output logic                       parityError,
  output logic [ERR_COUNT_WIDTH-1:0] errorCount,
  output logic                       stickyError
);

  localparam logic [ERR_COUNT_WIDTH-1:0] COUNT_MAX = '1;

  // Rank 1: raw input capture
  logic       s1_valid;
  logic [2:0] s1_code;
  logic [3:0] s1_data;
  logic       s1_parity;

  // Rank 2: checked and decoded beat
  logic       s2_valid;
  logic [7:0] s2_onehot;
  logic [3:0] s2_data;
  logic       s2_chk;

  // Combinational decode between rank 1 and rank 2
  logic [7:0] dec_onehot;
  logic       dec_chk;

  // A failing valid beat is being loaded into rank 3 on the coming edge
  logic       load_error;

  // Rank 1: capture every input on every edge, no backpressure
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_code   <= 3'd0;
      s1_data   <= 4'h0;
      s1_parity <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every rank samples the previous
      // rank's old value on the same edge; blocking here would collapse ranks.
      s1_valid  <= inValid;
      s1_code   <= encodedCode;
      s1_data   <= resultData;
      s1_parity <= parityBit;
    end
  end

  // One-hot decode of the code and even-parity check of the captured beat
  always_comb begin
    // NOTE: every output of this block gets a default before any conditional
    // or indexed write, otherwise synthesis infers a latch.
    dec_onehot          = 8'h00;
    dec_onehot[s1_code] = 1'b1;
    dec_chk             = (^s1_data) ^ s1_parity;
  end

  // Rank 2: register the checked/decoded beat
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_onehot <= 8'h00;
      s2_data   <= 4'h0;
      s2_chk    <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      s2_onehot <= dec_onehot;
      s2_data   <= s1_data;
      s2_chk    <= dec_chk;
    end
  end

  assign load_error = s2_valid & s2_chk;

  // Rank 3: output registers, zeroed whenever the beat is not valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outValid     <= 1'b0;
      functionCode <= 8'h00;
      resultOut    <= 4'h0;
      parityError  <= 1'b0;
    end else begin
      outValid     <= s2_valid;
      functionCode <= s2_valid ? s2_onehot : 8'h00;
      resultOut    <= s2_valid ? s2_data : 4'h0;
      parityError  <= load_error;
    end
  end

  // Error bookkeeping: clear has priority over a failing beat on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      errorCount  <= '0;
      stickyError <= 1'b0;
    end else if (clearErrors) begin
      errorCount  <= '0;
      stickyError <= 1'b0;
    end else if (load_error) begin
      stickyError <= 1'b1;
      if (errorCount != COUNT_MAX) begin
        errorCount <= errorCount + ERR_COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_check_decoder_3stage.sv
// Directed bench for parity_check_decoder_3stage. Two instances share the
// stimulus: an 8-bit counter instance and a 2-bit counter instance used for
// the saturation scenario.
module tb_parity_check_decoder_3stage;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] encoded_code;
  logic [3:0] result_data;
  logic       parity_bit;
  logic       clear_errors;

  logic       ov8, pe8, se8;
  logic [7:0] fc8;
  logic [3:0] ro8;
  logic [7:0] ec8;

  logic       ov2, pe2, se2;
  logic [7:0] fc2;
  logic [3:0] ro2;
  logic [1:0] ec2;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] ONEHOT_TBL [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                            8'h10, 8'h20, 8'h40, 8'h80};

  parity_check_decoder_3stage #(.ERR_COUNT_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .inValid(in_valid), .encodedCode(encoded_code),
    .resultData(result_data), .parityBit(parity_bit), .clearErrors(clear_errors),
    .outValid(ov8), .functionCode(fc8), .resultOut(ro8), .parityError(pe8),
    .errorCount(ec8), .stickyError(se8)
  );

  parity_check_decoder_3stage #(.ERR_COUNT_WIDTH(2)) dut2 (
    .clock(clock), .reset(reset), .inValid(in_valid), .encodedCode(encoded_code),
    .resultData(result_data), .parityBit(parity_bit), .clearErrors(clear_errors),
    .outValid(ov2), .functionCode(fc2), .resultOut(ro2), .parityError(pe2),
    .errorCount(ec2), .stickyError(se2)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [3:0] d, input logic p);
    in_valid     = v;
    encoded_code = c;
    result_data  = d;
    parity_bit   = p;
  endtask

  task automatic clear_now();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    clear_errors = 1'b0;
    #2 reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({ov8, fc8, ro8, pe8, ec8, se8} !== 23'd0) begin
      errors++;
      $display("FAIL reset_dut8 got %h expected 0", {ov8, fc8, ro8, pe8, ec8, se8});
    end
    checks++;
    if ({ov2, fc2, ro2, pe2, ec2, se2} !== 17'd0) begin
      errors++;
      $display("FAIL reset_dut2 got %h expected 0", {ov2, fc2, ro2, pe2, ec2, se2});
    end
    reset = 1'b1;
  endtask

  task automatic test_decode_passthrough();
    drive(1'b1, 3'd5, 4'b0110, 1'b0);
    tick();                               // edge 1: beat sampled
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    tick();                               // edge 2: not yet visible
    checks++;
    if (ov8 !== 1'b0) begin
      errors++;
      $display("FAIL latency_early outValid got %b expected 0", ov8);
    end
    tick();                               // edge 3: visible
    checks++;
    if ({ov8, fc8, ro8, pe8, ec8} !== {1'b1, 8'h20, 4'h6, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL decode_code5 got ov=%b fc=%h ro=%h pe=%b ec=%0d expected ov=1 fc=20 ro=6 pe=0 ec=0",
               ov8, fc8, ro8, pe8, ec8);
    end
    tick();
    checks++;
    if ({ov8, fc8, ro8} !== 13'd0) begin
      errors++;
      $display("FAIL decode_trailing got ov=%b fc=%h ro=%h expected zeros", ov8, fc8, ro8);
    end
  endtask

  task automatic test_error_detect();
    clear_now();
    drive(1'b1, 3'd2, 4'b0111, 1'b0);     // odd data, parity 0: error
    tick();
    drive(1'b1, 3'd3, 4'b0111, 1'b1);     // correct parity
    tick();
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    tick();
    checks++;
    if ({ov8, fc8, ro8, pe8, ec8, se8} !== {1'b1, 8'h04, 4'h7, 1'b1, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL error_beat got ov=%b fc=%h ro=%h pe=%b ec=%0d se=%b expected 1 04 7 1 1 1",
               ov8, fc8, ro8, pe8, ec8, se8);
    end
    tick();
    checks++;
    if ({ov8, fc8, ro8, pe8, ec8, se8} !== {1'b1, 8'h08, 4'h7, 1'b0, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL good_after_error got ov=%b fc=%h ro=%h pe=%b ec=%0d se=%b expected 1 08 7 0 1 1",
               ov8, fc8, ro8, pe8, ec8, se8);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 11; i++) begin
      if (i < 8) drive(1'b1, 3'(i), 4'(i), ^(4'(i)));
      else       drive(1'b0, 3'd0, 4'h0, 1'b0);
      tick();
      if (i >= 2) begin
        int j = i - 2;
        checks++;
        if (j < 8) begin
          if ({ov8, fc8, ro8, pe8} !== {1'b1, ONEHOT_TBL[j], 4'(j), 1'b0}) begin
            errors++;
            $display("FAIL stream_beat%0d got ov=%b fc=%h ro=%h pe=%b expected ov=1 fc=%h ro=%h pe=0",
                     j, ov8, fc8, ro8, pe8, ONEHOT_TBL[j], 4'(j));
          end
        end else if ({ov8, fc8, ro8, pe8} !== 14'd0) begin
          errors++;
          $display("FAIL stream_idle%0d got ov=%b fc=%h ro=%h pe=%b expected zeros", j, ov8, fc8, ro8, pe8);
        end
      end
    end
    checks++;
    if (ec8 !== 8'd1) begin
      errors++;
      $display("FAIL stream_count got %0d expected 1", ec8);
    end
  endtask

  task automatic test_saturation_clear();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clear_now();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(1'b1, 3'(i), 4'b0001, 1'b0);
      else       drive(1'b0, 3'd0, 4'h0, 1'b0);
      tick();
      if (i >= 2) begin
        checks++;
        if ({pe2, ec2, se2} !== {1'b1, exp_cnt[i-2], 1'b1}) begin
          errors++;
          $display("FAIL sat_step%0d got pe=%b ec=%0d se=%b expected pe=1 ec=%0d se=1",
                   i - 2, pe2, ec2, se2, exp_cnt[i-2]);
        end
      end
    end
    checks++;
    if (ec8 !== 8'd5) begin
      errors++;
      $display("FAIL sat_wide_count got %0d expected 5", ec8);
    end
    drive(1'b1, 3'd6, 4'b1011, 1'b0);     // odd data, parity 0: error
    tick();
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    tick();
    clear_errors = 1'b1;                  // same edge the bad beat reaches rank 3
    tick();
    clear_errors = 1'b0;
    checks++;
    if ({ov2, fc2, pe2, ec2, se2, ec8, se8} !== {1'b1, 8'h40, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL clear_priority got ov=%b fc=%h pe=%b ec2=%0d se2=%b ec8=%0d se8=%b expected 1 40 1 0 0 0 0",
               ov2, fc2, pe2, ec2, se2, ec8, se8);
    end
    tick();
    checks++;
    if ({ec2, se2, ec8, se8} !== 12'd0) begin
      errors++;
      $display("FAIL clear_hold got ec2=%0d se2=%b ec8=%0d se8=%b expected zeros", ec2, se2, ec8, se8);
    end
  endtask

  task automatic test_invalid_ignored();
    drive(1'b1, 3'd1, 4'b1000, 1'b0);     // one real error to make the count nonzero
    tick();
    drive(1'b0, 3'd4, 4'b0001, 1'b0);     // invalid beats with bad parity
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({ov8, fc8, ro8, pe8, ec8, se8} !== {1'b0, 8'h00, 4'h0, 1'b0, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL invalid_ignored got ov=%b fc=%h ro=%h pe=%b ec=%0d se=%b expected 0 00 0 0 1 1",
               ov8, fc8, ro8, pe8, ec8, se8);
    end
  endtask

  task automatic test_midstream_reset();
    drive(1'b1, 3'd7, 4'b0011, 1'b1);     // error beat
    tick();
    drive(1'b1, 3'd2, 4'b0101, 1'b0);
    tick();
    drive(1'b1, 3'd3, 4'b1001, 1'b0);
    tick();
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    checks++;
    if ({ov8, fc8, pe8, ec8} !== {1'b1, 8'h80, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL pre_reset got ov=%b fc=%h pe=%b ec=%0d expected 1 80 1 2", ov8, fc8, pe8, ec8);
    end
    #2 reset = 1'b0;                      // between edges
    #1;
    checks++;
    if ({ov8, fc8, ro8, pe8, ec8, se8} !== 23'd0) begin
      errors++;
      $display("FAIL async_reset got %h expected 0", {ov8, fc8, ro8, pe8, ec8, se8});
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({ov8, fc8, ro8, pe8, ec8, se8} !== 23'd0) begin
        errors++;
        $display("FAIL post_reset_cycle%0d got %h expected 0", i, {ov8, fc8, ro8, pe8, ec8, se8});
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode_passthrough();
    test_error_detect();
    test_back_to_back();
    test_saturation_clear();
    test_invalid_ignored();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_check_decoder_3stage.md
# parity_check_decoder_3stage

Receive-side counterpart of the 3-stage ALU/parity datapath. Each valid beat carries a 4-bit result, its even-parity bit and the 3-bit encoded function code. The block checks parity, decodes the code back to the one-hot 8-bit function code, and keeps a saturating error count and a sticky error flag. It is a fixed-latency, non-stalling three-rank pipeline on one clock.

## Interface
- ERR_COUNT_WIDTH, 8, width of the saturating parity-error counter
- clock  in  1  sole clock, rising-edge
- reset  in  1  asynchronous, active-low; clears every register while low
- inValid  in  1  beat qualifier; high means the other inputs are meaningful this cycle
- encodedCode  in  3  encoded function code (0..7)
- resultData  in  4  ALU result
- parityBit  in  1  even-parity bit sent with resultData
- clearErrors  in  1  synchronous clear of errorCount and stickyError
- outValid  out  1  output beat qualifier
- functionCode  out  8  one-hot decode of encodedCode; 0 when outValid low
- resultOut  out  4  resultData passed through; 0 when outValid low
- parityError  out  1  high when outValid high and the parity check failed
- errorCount  out  ERR_COUNT_WIDTH  number of failed beats, saturating at all-ones
- stickyError  out  1  set by the first failed beat, held until cleared

## Operation
- Rank 1 (capture): registers {inValid, encodedCode, resultData, parityBit} on every edge. There is no stall or backpressure.
- Rank 2 (check/decode):
  - Computes chk = ^resultData ^ parityBit; chk = 1 means a parity error.
  - Decodes code c to a one-hot value with only bit c set (code 0 gives 8'h01, code 7 gives 8'h80).
  - Registers the valid bit, the one-hot code, the data and chk.
- Rank 3 (output): registers the rank-2 contents onto the outputs.
  - When the rank-2 valid bit is 0: outValid=0, functionCode=0, resultOut=0, parityError=0.
  - parityError is the rank-2 chk AND the rank-2 valid bit.
- errorCount:
  - Increments on the edge where rank 3 loads a beat with parityError=1.
  - Holds at 2^ERR_COUNT_WIDTH-1 once reached and does not wrap.
- stickyError: set on that same edge; cleared only by clearErrors or reset.
- clearErrors:
  - Sampled on the edge; errorCount becomes 0 and stickyError becomes 0.
  - If a failing beat loads on the same edge, clear wins: count=0, sticky=0 and the beat is not counted. parityError is still reported for that beat.
  - Pipeline data is unaffected.
- Invalid beats never change the counter or the sticky flag, whatever their parity.

## Timing
- Reset (reset low, asynchronous) zeroes all ranks and all outputs: outValid=0, functionCode=8'h00, resultOut=4'h0, parityError=0, errorCount=0, stickyError=0.
- Beats in flight when reset asserts are discarded. The first beat sampled after reset release appears 2 edges later.
- Latency: a beat sampled at edge k is visible on the outputs after edge k+2. errorCount and stickyError reflect it after the same edge k+2.
- Throughput: one beat per cycle. Back-to-back beats appear back-to-back with gaps preserved, and beat order is preserved.
- All outputs are registered. There are no combinational paths from any input to any output.

## Test plan
- Reset, then check decode and passthrough:
  - Stimulus: release reset; drive inValid=1, encodedCode=3'd5, resultData=4'b0110, parityBit=0 at edge 1.
  - Required response: after edge 3, outValid=1, functionCode=8'h20, resultOut=4'h6, parityError=0, errorCount=0.
- Error detection:
  - Stimulus: beat with resultData=4'b0111, parityBit=0.
  - Required response: parityError=1 two edges later, errorCount=1, stickyError=1.
  - Follow-up: next beat with resultData=4'b0111, parityBit=1 gives parityError=0; errorCount stays 1 and stickyError stays 1.
- Streaming:
  - Stimulus: 8 consecutive valid beats with encodedCode 0..7, all with correct parity, then inValid=0.
  - Required response: functionCode 8'h01, 8'h02, ... 8'h80 on consecutive cycles, followed by outValid=0 and functionCode=0.
- Saturation and clear priority:
  - Stimulus: ERR_COUNT_WIDTH=2; send 5 bad beats.
  - Required response: errorCount goes 1, 2, 3, 3, 3.
  - Follow-up: assert clearErrors on the same edge a bad beat loads; errorCount=0, stickyError=0, parityError=1 for that beat.
- Invalid beats ignored:
  - Stimulus: inValid=0 with resultData=4'b0001, parityBit=0.
  - Required response: outValid=0, parityError=0, errorCount unchanged.
- Mid-stream reset:
  - Stimulus: assert reset low between edges while two valid beats are in flight.
  - Required response: all outputs 0 immediately, with no clock edge needed. After release, no stale beat ever appears.
